// File: rtl/battle_grid.sv
// Game-board controller for the grid shooting game: ship placement, shot history,
// row/column selection latch, fire resolution, display codes and game-over tracking.
module battle_grid #(
  parameter int GRID_N    = 4,
  parameter int MAX_SHOTS = 12,
  parameter int SHOT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [GRID_N-1:0]          sel,
  input  logic                       n_row,
  input  logic                       fire,
  input  logic                       start,
  input  logic                       load_en,
  input  logic [5:0]                 load_idx,
  output logic                       sel_error,
  output logic [2*GRID_N*GRID_N-1:0] cell_state,
  output logic                       result_valid,
  output logic [1:0]                 result,
  output logic [SHOT_W-1:0]          shots,
  output logic [6:0]                 hits,
  output logic [6:0]                 ships,
  output logic                       game_over,
  output logic                       win
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam logic [6:0]        CELLS_W = 7'(CELLS);
  localparam logic [SHOT_W-1:0] MAX_W   = SHOT_W'(MAX_SHOTS);

  typedef enum logic [1:0] {SETUP = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [CELLS-1:0]    ship_reg, shot_reg;
  logic [CELLS-1:0]    cell_sel, load_hit;
  logic [GRID_N-1:0]   row_reg, col_reg;
  logic [SHOT_W-1:0]   shots_reg, shots_next;
  logic [6:0]          hits_reg, hits_next, ships_reg, ships_next;
  logic                result_valid_reg;
  logic [1:0]          result_reg;

  logic load_ok, new_ship, fire_ok, tgt_shot, tgt_ship, new_shot, new_hit;

  // Selection is legal only when exactly one switch is on.
  assign sel_error = (sel == '0) || ((sel & (sel - 1'b1)) != '0);

  assign load_ok = (state_reg == SETUP) && load_en && ({1'b0, load_idx} < CELLS_W);

  // Both latches are one-hot, so at most one cell matches the cursor.
  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    assign cell_sel[gi] = row_reg[gi / GRID_N] & col_reg[gi % GRID_N];
    assign load_hit[gi] = load_ok && (load_idx == 6'(gi));
    assign cell_state[2*gi +: 2] = shot_reg[gi] ? (ship_reg[gi] ? 2'b10 : 2'b01)
                                                : (cell_sel[gi] ? 2'b11 : 2'b00);
  end

  assign new_ship = |(load_hit & ~ship_reg);
  assign fire_ok  = (state_reg == PLAY) && fire && (|row_reg) && (|col_reg);
  assign tgt_shot = |(cell_sel & shot_reg);
  assign tgt_ship = |(cell_sel & ship_reg);
  assign new_shot = fire_ok && !tgt_shot;
  assign new_hit  = new_shot && tgt_ship;

  assign shots_next = (new_shot && shots_reg < MAX_W)     ? shots_reg + 1'b1 : shots_reg;
  assign hits_next  = (new_hit  && hits_reg  < ships_reg) ? hits_reg  + 1'b1 : hits_reg;
  assign ships_next = (new_ship && ships_reg < 7'd64)     ? ships_reg + 1'b1 : ships_reg;

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= SETUP;
    else        state_reg <= state_next;
  end

  // Start is judged on the ship count before any load in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SETUP:   if (start && ships_reg != 7'd0) state_next = PLAY;
      PLAY:    if (new_shot && (hits_next == ships_reg || shots_next >= MAX_W)) state_next = OVER;
      OVER:    state_next = OVER;
      default: state_next = SETUP;
    endcase
  end

  always_comb begin
    game_over = 1'b0;
    win       = 1'b0;
    if (state_reg == OVER) begin
      game_over = 1'b1;
      win       = (hits_reg == ships_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ship_reg         <= '0;
      shot_reg         <= '0;
      row_reg          <= '0;
      col_reg          <= '0;
      shots_reg        <= '0;
      hits_reg         <= '0;
      ships_reg        <= '0;
      result_valid_reg <= 1'b0;
      result_reg       <= 2'b00;
    end else begin
      ship_reg         <= ship_reg | load_hit;
      shot_reg         <= shot_reg | (cell_sel & {CELLS{new_shot}});
      shots_reg        <= shots_next;
      hits_reg         <= hits_next;
      ships_reg        <= ships_next;
      result_valid_reg <= fire_ok;
      if (fire_ok)
        result_reg <= tgt_shot ? 2'b11 : (tgt_ship ? 2'b10 : 2'b01);
      if (!sel_error) begin
        if (n_row) col_reg <= sel;
        else       row_reg <= sel;
      end
    end
  end

  assign result_valid = result_valid_reg;
  assign result       = result_reg;
  assign shots        = shots_reg;
  assign hits         = hits_reg;
  assign ships        = ships_reg;

endmodule

// File: tb/tb_battle_grid.sv
// Directed and randomized bench for battle_grid with a cell-array game model.
module tb_battle_grid;
  localparam int N     = 4;
  localparam int CELLS = N * N;
  localparam int MAXS  = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   sel = '0;
  logic           n_row = 1'b0, fire = 1'b0, start = 1'b0, load_en = 1'b0;
  logic [5:0]     load_idx = '0;
  logic           sel_error, result_valid, game_over, win;
  logic [2*CELLS-1:0] cell_state;
  logic [1:0]     result;
  logic [7:0]     shots;
  logic [6:0]     hits, ships;

  battle_grid #(.GRID_N(N), .MAX_SHOTS(MAXS), .SHOT_W(8)) dut (
    .clk(clk), .reset(reset), .sel(sel), .n_row(n_row), .fire(fire), .start(start),
    .load_en(load_en), .load_idx(load_idx), .sel_error(sel_error), .cell_state(cell_state),
    .result_valid(result_valid), .result(result), .shots(shots), .hits(hits),
    .ships(ships), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Game model: 0 = setup, 1 = play, 2 = over; row/col are -1 when nothing selected.
  bit m_ship[CELLS];
  bit m_shot[CELLS];
  int m_shots, m_hits, m_ships, m_row, m_col, m_state, m_res;
  bit m_rv, m_was_reset;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int ps, pr, pc, ships_pre, k, idx;
    ps = m_state; pr = m_row; pc = m_col; ships_pre = m_ships;
    m_rv = 0;
    m_was_reset = !reset;
    if (!reset) begin
      foreach (m_ship[i]) begin m_ship[i] = 0; m_shot[i] = 0; end
      m_shots = 0; m_hits = 0; m_ships = 0; m_state = 0; m_res = 0;
      m_row = -1; m_col = -1;
    end else begin
      if (ps == 1 && fire && pr >= 0 && pc >= 0) begin
        k = pr * N + pc;
        m_rv = 1;
        if (m_shot[k]) m_res = 3;
        else begin
          m_shot[k] = 1;
          if (m_shots < MAXS) m_shots++;
          if (m_ship[k]) begin
            m_res = 2;
            if (m_hits < m_ships) m_hits++;
          end else m_res = 1;
          if (m_hits == m_ships || m_shots >= MAXS) m_state = 2;
        end
      end
      if (ps == 0) begin
        if (load_en && int'(load_idx) < CELLS && !m_ship[load_idx]) begin
          m_ship[load_idx] = 1;
          m_ships++;
        end
        if (start && ships_pre > 0) m_state = 1;
      end
      if ($countones(sel) == 1) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (sel[i]) idx = i;
        if (n_row) m_col = idx;
        else       m_row = idx;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] exp_cells;
    int cur;
    exp_cells = '0;
    cur = (m_row >= 0 && m_col >= 0) ? m_row * N + m_col : -1;
    for (int k = 0; k < CELLS; k++) begin
      if (m_shot[k])    exp_cells[2*k +: 2] = m_ship[k] ? 2'b10 : 2'b01;
      else if (k == cur) exp_cells[2*k +: 2] = 2'b11;
    end
    check("result_valid", 64'(result_valid), 64'(m_rv));
    if (m_rv || m_was_reset) check("result", 64'(result), 64'(m_res));
    check("shots", 64'(shots), 64'(m_shots));
    check("hits", 64'(hits), 64'(m_hits));
    check("ships", 64'(ships), 64'(m_ships));
    check("game_over", 64'(game_over), 64'(m_state == 2));
    check("win", 64'(win), 64'(m_state == 2 && m_hits == m_ships));
    check("cell_state", 64'(cell_state), exp_cells);
    check("sel_error", 64'(sel_error), 64'($countones(sel) != 1));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    fire = 0; start = 0; load_en = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 0;
    repeat (n) tick();
    reset = 1;
  endtask

  task automatic load(input int idx);
    load_en = 1; load_idx = 6'(idx);
    tick();
  endtask

  task automatic shoot(input int r, input int c);
    sel = 4'(1 << r); n_row = 0; tick();
    sel = 4'(1 << c); n_row = 1; tick();
    fire = 1; tick();
  endtask

  initial begin
    do_reset(2);
    start = 1; tick();                    // ignored: no ships yet
    load(5); load(5); load(20); load(10);
    start = 1; tick();
    shoot(1, 1);                          // hit on idx 5
    fire = 1; tick();                     // same cell again: repeat
    shoot(0, 0);                          // miss
    fire = 1; tick();                     // repeat, shots unchanged
    sel = 4'b0110; n_row = 0; tick();     // illegal selection, row held
    shoot(2, 2);                          // second hit: win
    fire = 1; tick();                     // dropped in OVER

    do_reset(1);
    load(5); load(6);
    start = 1; tick();
    shoot(1, 1);
    do_reset(1);                          // mid-game reset with hits=1
    sel = 4'b1000; n_row = 0; tick();
    sel = 4'b0001; n_row = 1; tick();     // cursor on cell 12
    load_en = 1; load_idx = 6'd3; start = 1; tick();   // start uses pre-load count
    start = 1; tick();
    for (int k = 4; k < 16; k++) shoot(k / N, k % N);  // exhaust shot budget
    shoot(0, 3);

    for (int g = 0; g < 8; g++) begin
      do_reset(1);
      repeat ($urandom_range(1, 4)) load($urandom_range(0, 17));
      start = 1; tick();
      repeat (120) begin
        reset    = 1'($urandom_range(0, 149) != 0);
        sel      = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        n_row    = 1'($urandom_range(0, 1));
        fire     = 1'($urandom_range(0, 1));
        load_en  = 1'($urandom_range(0, 9) == 0);
        load_idx = 6'($urandom_range(0, 17));
        start    = 1'($urandom_range(0, 9) == 0);
        tick();
      end
      reset = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
